// File: rtl/bolt_pkg.sv
// Shared types and constants for the player bolt path: shot FSM states,
// screen height and the coordinate type used by the trajectory block.
package bolt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        FLIGHT   = 2'd2,
        COOLDOWN = 2'd3
    } shot_state_t;

    localparam int SCREEN_HEIGHT = 480;
    localparam int COORD_W       = 11;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector; the previous-value register resets to
// RESET_VAL so a level already high at reset release is not seen as an edge.
module rise_det #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= RESET_VAL;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/bolt_shot_ctrl.sv
// Player-shot controller: one bolt at a time, launch position latched on the
// fire edge, flight ended by collision or leaving the screen, frame cooldown.
module bolt_shot_ctrl
    import bolt_pkg::*;
#(
    parameter int Y_LIMIT         = SCREEN_HEIGHT,
    parameter int ARM_CYCLES      = 2,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       gameEnable,
    input  logic       fireBtn,
    input  coord_t     playerX,
    input  coord_t     playerY,
    input  coord_t     boltY,
    input  logic       hit,
    output logic       shootCmd,
    output coord_t     initX,
    output coord_t     initY,
    output logic       hitPulse,
    output logic [7:0] shotCount
);

    localparam int AW = $clog2(ARM_CYCLES + 1);
    localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [AW-1:0] ARM_LOAD = AW'(ARM_CYCLES - 1);
    localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN_FRAMES);
    localparam coord_t        Y_LIM_C  = coord_t'(Y_LIMIT);

    shot_state_t     state, state_n;
    logic [AW-1:0]   arm_cnt, arm_cnt_n;
    logic [CW-1:0]   cd_cnt, cd_cnt_n;
    logic            shoot_n, hit_pulse_n;
    coord_t          init_x_n, init_y_n;
    logic [7:0]      shot_count_n;
    logic            fire_rise;

    rise_det #(.RESET_VAL(1'b1)) u_fire_edge (
        .clk   (clk),
        .reset (reset),
        .d     (fireBtn),
        .rise  (fire_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            arm_cnt   <= '0;
            cd_cnt    <= '0;
            shootCmd  <= 1'b0;
            hitPulse  <= 1'b0;
            initX     <= '0;
            initY     <= '0;
            shotCount <= '0;
        end else begin
            state     <= state_n;
            arm_cnt   <= arm_cnt_n;
            cd_cnt    <= cd_cnt_n;
            shootCmd  <= shoot_n;
            hitPulse  <= hit_pulse_n;
            initX     <= init_x_n;
            initY     <= init_y_n;
            shotCount <= shot_count_n;
        end
    end

    always_comb begin
        state_n      = state;
        arm_cnt_n    = arm_cnt;
        cd_cnt_n     = cd_cnt;
        shoot_n      = shootCmd;
        hit_pulse_n  = 1'b0;
        init_x_n     = initX;
        init_y_n     = initY;
        shot_count_n = shotCount;

        if (!gameEnable) begin
            // Abort skips the cooldown; the shot counter is kept.
            state_n = IDLE;
            shoot_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire_rise) begin
                        state_n   = ARM;
                        shoot_n   = 1'b1;
                        init_x_n  = playerX;
                        init_y_n  = playerY;
                        arm_cnt_n = ARM_LOAD;
                        if (shotCount != 8'd255) begin
                            shot_count_n = shotCount + 8'd1;
                        end
                    end
                end
                ARM: begin
                    // boltY still holds the previous shot's value here.
                    if (arm_cnt == '0) begin
                        state_n = FLIGHT;
                    end else begin
                        arm_cnt_n = arm_cnt - AW'(1);
                    end
                end
                FLIGHT: begin
                    if (hit || (boltY >= Y_LIM_C)) begin
                        state_n     = COOLDOWN;
                        shoot_n     = 1'b0;
                        hit_pulse_n = hit;
                        cd_cnt_n    = CD_LOAD;
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == '0) begin
                        state_n = IDLE;
                    end else if (startOfFrame) begin
                        cd_cnt_n = cd_cnt - CW'(1);
                        if (cd_cnt == CW'(1)) begin
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bolt_shot_ctrl.sv
// Bench for bolt_shot_ctrl with default parameters (Y_LIMIT 480, ARM 2, cooldown 8).
module tb_bolt_shot_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        gameEnable = 1'b1;
    logic        fireBtn = 1'b1;
    logic [10:0] playerX = '0;
    logic [10:0] playerY = '0;
    logic [10:0] boltY = '0;
    logic        hit = 1'b0;
    logic        shootCmd;
    logic [10:0] initX;
    logic [10:0] initY;
    logic        hitPulse;
    logic [7:0]  shotCount;

    int vectors = 0;
    int miscompares = 0;
    logic [29:0] exp_q[$];
    logic [29:0] mon_exp;
    logic [7:0]  exp_count = 8'd0;
    logic        prev_shoot = 1'b0;
    int          total_launch = 0;

    bolt_shot_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .gameEnable   (gameEnable),
        .fireBtn      (fireBtn),
        .playerX      (playerX),
        .playerY      (playerY),
        .boltY        (boltY),
        .hit          (hit),
        .shootCmd     (shootCmd),
        .initX        (initX),
        .initY        (initY),
        .hitPulse     (hitPulse),
        .shotCount    (shotCount)
    );

    always #5 clk = ~clk;

    // Scoreboard: every rising shootCmd must match the next expected launch.
    always @(negedge clk) begin
        if (shootCmd === 1'b1 && prev_shoot !== 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_launch: got x=%0d y=%0d count=%0d, expected no launch",
                         initX, initY, shotCount);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({initX, initY, shotCount} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL launch_sb: got x=%0d y=%0d count=%0d, expected x=%0d y=%0d count=%0d",
                             initX, initY, shotCount, mon_exp[29:19], mon_exp[18:8], mon_exp[7:0]);
                end
            end
        end
        prev_shoot = shootCmd;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge with IDLE state and fireBtn low; returns one negedge later.
    task automatic launch(input logic [10:0] x, input logic [10:0] y);
        if (exp_count != 8'd255) exp_count = exp_count + 8'd1;
        total_launch++;
        exp_q.push_back({x, y, exp_count});
        playerX = x;
        playerY = y;
        fireBtn = 1'b1;
        tick();
        fireBtn = 1'b0;
    endtask

    task automatic cooldown_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fireBtn = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({shootCmd, hitPulse, initX, initY, shotCount} !== 31'd0) begin
            miscompares++;
            $display("FAIL reset_values: got shoot=%b hp=%b x=%0d y=%0d cnt=%0d, expected all 0",
                     shootCmd, hitPulse, initX, initY, shotCount);
        end
        reset = 1'b0;
        repeat (4) tick();
        vectors++;
        if (shootCmd !== 1'b0) begin
            miscompares++;
            $display("FAIL held_through_reset: got shoot=%b, expected 0", shootCmd);
        end
        fireBtn = 1'b0;
        tick();
    endtask

    task automatic test_launch();
        boltY = 11'd440;
        launch(11'd300, 11'd440);
        vectors++;
        if ({shootCmd, initX, initY, shotCount} !== {1'b1, 11'd300, 11'd440, 8'd1}) begin
            miscompares++;
            $display("FAIL launch: got shoot=%b x=%0d y=%0d cnt=%0d, expected 1 300 440 1",
                     shootCmd, initX, initY, shotCount);
        end
        playerX = 11'd5;
        playerY = 11'd6;
        tick();
        tick();
        vectors++;
        if ({shootCmd, initX, initY} !== {1'b1, 11'd300, 11'd440}) begin
            miscompares++;
            $display("FAIL init_stable: got shoot=%b x=%0d y=%0d, expected 1 300 440",
                     shootCmd, initX, initY);
        end
    endtask

    task automatic test_offscreen();
        for (int y = 430; y >= 0; y -= 10) begin
            boltY = 11'(y);
            fireBtn = (y == 200);
            tick();
            vectors++;
            if (shootCmd !== 1'b1 || shotCount !== 8'd1) begin
                miscompares++;
                $display("FAIL in_flight y=%0d: got shoot=%b cnt=%0d, expected 1 1", y, shootCmd, shotCount);
            end
        end
        fireBtn = 1'b0;
        boltY = 11'd2042;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        boltY = 11'd100;
        vectors++;
        if (shootCmd !== 1'b0 || hitPulse !== 1'b0) begin
            miscompares++;
            $display("FAIL offscreen_end: got shoot=%b hp=%b, expected 0 0", shootCmd, hitPulse);
        end
        tick();
        vectors++;
        if (hitPulse !== 1'b0) begin
            miscompares++;
            $display("FAIL offscreen_nopulse: got hp=%b, expected 0", hitPulse);
        end
        cooldown_pulses(7);
        fireBtn = 1'b1;
        tick();
        fireBtn = 1'b0;
        tick();
        vectors++;
        if (shootCmd !== 1'b0 || shotCount !== 8'd1) begin
            miscompares++;
            $display("FAIL cooldown_discard: got shoot=%b cnt=%0d, expected 0 1", shootCmd, shotCount);
        end
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        launch(11'd100, 11'd200);
        vectors++;
        if (shootCmd !== 1'b1 || initX !== 11'd100) begin
            miscompares++;
            $display("FAIL after_cooldown: got shoot=%b x=%0d, expected 1 100", shootCmd, initX);
        end
    endtask

    task automatic test_hit();
        hit = 1'b1;
        boltY = 11'd500;
        tick();
        vectors++;
        if (shootCmd !== 1'b1 || hitPulse !== 1'b0) begin
            miscompares++;
            $display("FAIL arm_ignore1: got shoot=%b hp=%b, expected 1 0", shootCmd, hitPulse);
        end
        tick();
        vectors++;
        if (shootCmd !== 1'b1 || hitPulse !== 1'b0) begin
            miscompares++;
            $display("FAIL arm_ignore2: got shoot=%b hp=%b, expected 1 0", shootCmd, hitPulse);
        end
        tick();
        vectors++;
        if (shootCmd !== 1'b0 || hitPulse !== 1'b1) begin
            miscompares++;
            $display("FAIL hit_end: got shoot=%b hp=%b, expected 0 1", shootCmd, hitPulse);
        end
        hit = 1'b0;
        boltY = 11'd100;
        fireBtn = 1'b1;
        tick();
        vectors++;
        if (hitPulse !== 1'b0) begin
            miscompares++;
            $display("FAIL hit_pulse_width: got hp=%b, expected 0", hitPulse);
        end
        cooldown_pulses(8);
        repeat (3) tick();
        vectors++;
        if (shootCmd !== 1'b0 || shotCount !== 8'd2) begin
            miscompares++;
            $display("FAIL held_key: got shoot=%b cnt=%0d, expected 0 2", shootCmd, shotCount);
        end
        fireBtn = 1'b0;
        tick();
        launch(11'd50, 11'd60);
        vectors++;
        if (shootCmd !== 1'b1 || initX !== 11'd50 || shotCount !== 8'd3) begin
            miscompares++;
            $display("FAIL repress: got shoot=%b x=%0d cnt=%0d, expected 1 50 3", shootCmd, initX, shotCount);
        end
    endtask

    task automatic test_abort();
        tick();
        tick();
        gameEnable = 1'b0;
        tick();
        vectors++;
        if (shootCmd !== 1'b0 || hitPulse !== 1'b0 || shotCount !== 8'd3 || initX !== 11'd50) begin
            miscompares++;
            $display("FAIL abort: got shoot=%b hp=%b cnt=%0d x=%0d, expected 0 0 3 50",
                     shootCmd, hitPulse, shotCount, initX);
        end
        fireBtn = 1'b1;
        tick();
        fireBtn = 1'b0;
        vectors++;
        if (shootCmd !== 1'b0) begin
            miscompares++;
            $display("FAIL disabled_fire: got shoot=%b, expected 0", shootCmd);
        end
        gameEnable = 1'b1;
        tick();
        launch(11'd700, 11'd10);
        vectors++;
        if (shootCmd !== 1'b1 || initY !== 11'd10) begin
            miscompares++;
            $display("FAIL abort_no_cooldown: got shoot=%b y=%0d, expected 1 10", shootCmd, initY);
        end
        gameEnable = 1'b0;
        tick();
        gameEnable = 1'b1;
        vectors++;
        if (shootCmd !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_arm: got shoot=%b, expected 0", shootCmd);
        end
        tick();
    endtask

    task automatic test_saturation();
        while (total_launch < 258) begin
            launch(11'($urandom_range(0, 639)), 11'($urandom_range(0, 479)));
            tick();
            tick();
            hit = 1'b1;
            tick();
            hit = 1'b0;
            cooldown_pulses(8);
        end
        vectors++;
        if (shotCount !== 8'd255) begin
            miscompares++;
            $display("FAIL saturation: got cnt=%0d, expected 255", shotCount);
        end
    endtask

    task automatic test_reset_mid_flight();
        launch(11'd1, 11'd2);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({shootCmd, hitPulse, initX, initY, shotCount} !== 31'd0) begin
            miscompares++;
            $display("FAIL async_reset: got shoot=%b hp=%b x=%0d y=%0d cnt=%0d, expected all 0",
                     shootCmd, hitPulse, initX, initY, shotCount);
        end
        tick();
        reset = 1'b0;
        exp_count = 8'd0;
        tick();
    endtask

    initial begin
        test_reset();
        test_launch();
        test_offscreen();
        test_hit();
        test_abort();
        test_saturation();
        test_reset_mid_flight();
        repeat (2) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_launch: got %0d unmatched, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
